// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uart_tx between N byte requesters.
//
// Ports:
//   clk          clock shared with uart_tx
//   rst          asynchronous active-low reset
//   req          per-requester level request, held with its data until ack
//   req_data     packed request bytes, requester i at [8*i+7:8*i]
//   ack          one-cycle pulse: byte from requester i has been latched
//   tx_data      byte presented to uart_tx, stable from grant to end of BUSY
//   tx_start     one-cycle start pulse to uart_tx
//   tx_done      completion pulse from uart_tx (only honoured in BUSY)
//   grant_id     index of the current or last granted requester
//   busy         high whenever the scheduler is not idle
//   sent         one-cycle pulse when tx_done is accepted
//   timeout_err  one-cycle pulse when the watchdog aborts a transfer
module uart_tx_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [8*N-1:0]       req_data,
    output logic [N-1:0]         ack,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_done,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 sent,
    output logic                 timeout_err
);

    localparam int unsigned IdW = $clog2(N);
    localparam logic [15:0] ToLast  = 16'(TIMEOUT - 1);
    // Only used when GAP_CYCLES > 0.
    localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StGap} state_e;

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [IdW-1:0]   last_q, last_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [N-1:0]     ack_q, ack_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;
    logic             terr_q, terr_d;
    logic [IdW-1:0]   winner;

    // Round-robin search upward from last+1. Walking the offsets from the far end
    // down lets the nearest requesting index overwrite the farther ones.
    always_comb begin
        int idx;
        winner = last_q;
        for (int off = int'(N); off >= 1; off--) begin
            idx = int'(last_q) + off;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (req[idx]) begin
                winner = IdW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        ack_d     = '0;
        sent_d    = 1'b0;
        terr_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (|req) begin
                    tx_data_d     = req_data[8*winner +: 8];
                    ack_d[winner] = 1'b1;
                    grant_d       = winner;
                    last_d        = winner;
                    state_d       = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                // tx_done wins over a watchdog expiry on the same cycle.
                if (tx_done || (cnt_q == ToLast)) begin
                    sent_d  = tx_done;
                    terr_d  = !tx_done;
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered decodes of the next state keep busy/tx_start free of req paths.
        busy_d     = (state_d != StIdle);
        tx_start_d = (state_d == StStart);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_q     <= IdW'(N - 1);
            grant_q    <= '0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
            terr_q     <= terr_d;
        end
    end

    assign ack         = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign sent        = sent_q;
    assign timeout_err = terr_q;

endmodule
